// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-port word memory behind a one-request-at-a-time handshake. A request
// is accepted when req_valid is high while the responder is IDLE. Writes commit
// on the acceptance edge and are acknowledged one cycle later. Reads respond
// RD_LATENCY cycles after acceptance. Every response is a one-cycle valid_data
// pulse. Requests addressing a word at or beyond MEM_DEPTH still get a response,
// but with resp_err set. Such writes are dropped and such reads return zero.
//
// Parameters
//   DATA_WIDTH  width of a data word
//   MEM_DEPTH   number of words in storage
//   RD_LATENCY  read latency in cycles, 1..8
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset (storage is not cleared)
//   req_valid   request present
//   we          1 = write, 0 = read
//   addr        word index
//   data        write data
//   req_ready   responder idle, request can be accepted this cycle
//   valid_data  one-cycle response pulse
//   rdata       read data (zero for write acks and out-of-range reads)
//   resp_err    response addressed a word at or beyond MEM_DEPTH
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 64,
    parameter  int RD_LATENCY = 2,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  req_ready,
    output logic                  valid_data,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  resp_err
);

    localparam int                  CNT_W     = 4;
    // One extra bit so that MEM_DEPTH itself is representable for the compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_accept;
    logic                  w_req_in_range;
    logic                  w_cap_in_range;

    assign w_accept       = req_valid && (r_state == IDLE);
    assign w_req_in_range = ({1'b0, addr}   < DEPTH_EXT);
    assign w_cap_in_range = ({1'b0, r_addr} < DEPTH_EXT);

    // State, latency counter and captured request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we   <= we;
                r_addr <= addr;
                r_cnt  <= CNT_W'(RD_LATENCY - 1);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset. A write commits on its
    // acceptance edge, so an abort by reset afterwards does not undo it.
    always_ff @(posedge clk) begin
        if (w_accept && we && w_req_in_range) begin
            r_mem[addr] <= data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    // With a single-cycle read latency there is nothing to wait for.
                    if (we || (RD_LATENCY == 1)) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The read is taken from the array during RESP. A write that landed
    // earlier to the same word is therefore always visible.
    always_comb begin
        req_ready  = (r_state == IDLE);
        valid_data = 1'b0;
        rdata      = '0;
        resp_err   = 1'b0;
        if (r_state == RESP) begin
            valid_data = 1'b1;
            resp_err   = !w_cap_in_range;
            if (!r_we && w_cap_in_range) begin
                rdata = r_mem[r_addr];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. It uses three instances:
//   u_dut0  defaults (MEM_DEPTH=64, RD_LATENCY=2)
//   u_dut1  MEM_DEPTH=48, RD_LATENCY=3 (covers out-of-range handling)
//   u_dut2  RD_LATENCY=1
// All instances share clk and reset. Each one has its own request inputs.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  rv = '0;
    logic [2:0]  wr = '0;
    logic [5:0]  ad [3];
    logic [31:0] dd [3];
    logic [2:0]  rdy;
    logic [2:0]  vd;
    logic [2:0]  err;
    logic [31:0] rd [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_responder u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .we(wr[0]), .addr(ad[0]),
        .data(dd[0]), .req_ready(rdy[0]), .valid_data(vd[0]), .rdata(rd[0]),
        .resp_err(err[0])
    );

    data_mem_responder #(.DATA_WIDTH(32), .MEM_DEPTH(48), .RD_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .we(wr[1]), .addr(ad[1]),
        .data(dd[1]), .req_ready(rdy[1]), .valid_data(vd[1]), .rdata(rd[1]),
        .resp_err(err[1])
    );

    data_mem_responder #(.DATA_WIDTH(32), .MEM_DEPTH(64), .RD_LATENCY(1)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(rv[2]), .we(wr[2]), .addr(ad[2]),
        .data(dd[2]), .req_ready(rdy[2]), .valid_data(vd[2]), .rdata(rd[2]),
        .resp_err(err[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full transaction on instance s, starting from IDLE.
    // The inputs are scrambled right after acceptance so that the bench
    // confirms the captured copy is the one that is used.
    task automatic xact(input int s, input logic w, input logic [5:0] a,
                        input logic [31:0] d, input int lat,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
        int n;
        n = w ? 1 : lat;
        check({tag, "_ready"}, 32'(rdy[s]), 32'd1);
        rv[s] = 1'b1; wr[s] = w; ad[s] = a; dd[s] = d;
        step();
        rv[s] = 1'b0; ad[s] = ~a; dd[s] = ~d; wr[s] = ~w;
        for (int k = 1; k < n; k++) begin
            check({tag, "_early_vd"}, 32'(vd[s]), 32'd0);
            step();
        end
        check({tag, "_vd"},    32'(vd[s]),  32'd1);
        check({tag, "_rdata"}, rd[s],       exp_rd);
        check({tag, "_err"},   32'(err[s]), 32'(exp_err));
        check({tag, "_busy"},  32'(rdy[s]), 32'd0);
        step();
        check({tag, "_vd_off"}, 32'(vd[s]), 32'd0);
        wr[s] = 1'b0;
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 3; i++) begin
            ad[i] = '0;
            dd[i] = '0;
        end

        // Asynchronous reset: outputs must settle before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_vd",    32'(vd[0]),  32'd0);
        check("rst_rdata", rd[0],       32'd0);
        check("rst_err",   32'(err[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        step();
        step();
        reset = 1'b0;

        // First request accepted on the very first edge after release.
        xact(0, 1'b1, 6'd5,  32'hDEADBEEF, 2, 32'h0, 1'b0, "wr5");
        xact(0, 1'b0, 6'd5,  32'h0,        2, 32'hDEADBEEF, 1'b0, "rd5");
        xact(0, 1'b1, 6'd63, 32'h12345678, 2, 32'h0, 1'b0, "wr63");
        xact(0, 1'b0, 6'd63, 32'h0,        2, 32'h12345678, 1'b0, "rd63");
        xact(0, 1'b1, 6'd7,  32'h77770007, 2, 32'h0, 1'b0, "wr7");
        xact(0, 1'b1, 6'd9,  32'h99990009, 2, 32'h0, 1'b0, "wr9");

        // Busy drop: req_valid held high, address changed while waiting.
        rv[0] = 1'b1; wr[0] = 1'b0; ad[0] = 6'd7;
        step();
        ad[0] = 6'd9;
        check("busy_wait_ready", 32'(rdy[0]), 32'd0);
        check("busy_wait_vd",    32'(vd[0]),  32'd0);
        step();
        check("busy_resp_vd",    32'(vd[0]),  32'd1);
        check("busy_resp_rdata", rd[0],       32'h77770007);
        step();
        check("busy_idle_vd",    32'(vd[0]),  32'd0);
        check("busy_idle_ready", 32'(rdy[0]), 32'd1);
        step();
        check("busy2_wait_vd",   32'(vd[0]),  32'd0);
        step();
        check("busy2_resp_vd",   32'(vd[0]),  32'd1);
        check("busy2_rdata",     rd[0],       32'h99990009);
        rv[0] = 1'b0;
        step();
        check("busy2_vd_off",    32'(vd[0]),  32'd0);

        // Reset while a read waits: no response, memory retained.
        rv[0] = 1'b1; wr[0] = 1'b0; ad[0] = 6'd5;
        step();
        rv[0] = 1'b0;
        check("midrst_wait_vd", 32'(vd[0]), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_vd",    32'(vd[0]),  32'd0);
        check("midrst_ready", 32'(rdy[0]), 32'd1);
        check("midrst_rdata", rd[0],       32'd0);
        step();
        step();
        reset = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            step();
            if (vd[0] !== 1'b0) ok = 1'b0;
        end
        check("midrst_no_resp", 32'(ok), 32'd1);
        xact(0, 1'b0, 6'd5, 32'h0, 2, 32'hDEADBEEF, 1'b0, "rd5_after_rst");

        // MEM_DEPTH=48: out-of-range write dropped, read returns 0 with err.
        xact(1, 1'b1, 6'd0,  32'h00000AAA, 3, 32'h0, 1'b0, "d48_wr0");
        xact(1, 1'b1, 6'd2,  32'h22222222, 3, 32'h0, 1'b0, "d48_wr2");
        xact(1, 1'b1, 6'd18, 32'h18181818, 3, 32'h0, 1'b0, "d48_wr18");
        xact(1, 1'b1, 6'd47, 32'h47474747, 3, 32'h0, 1'b0, "d48_wr47");
        xact(1, 1'b1, 6'd50, 32'hA5A5A5A5, 3, 32'h0, 1'b1, "d48_wr50");
        xact(1, 1'b0, 6'd50, 32'h0,        3, 32'h0, 1'b1, "d48_rd50");
        xact(1, 1'b0, 6'd0,  32'h0,        3, 32'h00000AAA, 1'b0, "d48_rd0");
        xact(1, 1'b0, 6'd2,  32'h0,        3, 32'h22222222, 1'b0, "d48_rd2");
        xact(1, 1'b0, 6'd18, 32'h0,        3, 32'h18181818, 1'b0, "d48_rd18");
        xact(1, 1'b0, 6'd47, 32'h0,        3, 32'h47474747, 1'b0, "d48_rd47");

        // RD_LATENCY=1: back-to-back reads respond at +1 and +3.
        xact(2, 1'b1, 6'd0, 32'hC0C0C0C0, 1, 32'h0, 1'b0, "l1_wr0");
        xact(2, 1'b1, 6'd1, 32'hC1C1C1C1, 1, 32'h0, 1'b0, "l1_wr1");
        rv[2] = 1'b1; wr[2] = 1'b0; ad[2] = 6'd0;
        step();
        ad[2] = 6'd1;
        check("l1_p1_vd",    32'(vd[2]),  32'd1);
        check("l1_p1_rdata", rd[2],       32'hC0C0C0C0);
        step();
        check("l1_p2_vd",    32'(vd[2]),  32'd0);
        check("l1_p2_ready", 32'(rdy[2]), 32'd1);
        step();
        rv[2] = 1'b0;
        check("l1_p3_vd",    32'(vd[2]),  32'd1);
        check("l1_p3_rdata", rd[2],       32'hC1C1C1C1);
        step();
        check("l1_p4_vd",    32'(vd[2]),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
